// File: rtl/rob_commit_unit.sv
`default_nettype none
// ============================================================================
// Module   : rob_commit_unit
// Brief    : Retires the ROB head entry. Serialises store retirement with the
//            store buffer, turns a mispredict into a timed flush plus redirect,
//            and counts retired instructions.
// Revision : 1.0  initial release
// ============================================================================
module rob_commit_unit #(
    parameter int ROB_IDX      = 5,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               head_valid,
    input  logic               head_done,
    input  logic [ROB_IDX-1:0] head_idx,
    input  logic [4:0]         head_rd,
    input  logic [31:0]        head_value,
    input  logic               head_is_store,
    input  logic               head_mispred,
    input  logic [31:0]        head_target,
    input  logic               st_commit_ack,
    output logic               commit,
    output logic               rf_we,
    output logic [4:0]         rf_rd,
    output logic [31:0]        rf_data,
    output logic [ROB_IDX-1:0] rf_tag,
    output logic               st_commit_req,
    output logic               flush,
    output logic               redirect_valid,
    output logic [31:0]        redirect_pc,
    output logic [31:0]        retired_cnt
);

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_STORE = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  fcnt_q, fcnt_d;
    logic        req_q, req_d;
    logic        flush_q, flush_d;
    logic        rv_q, rv_d;
    logic [31:0] rpc_q, rpc_d;
    logic [31:0] retired_cnt_q, retired_cnt_d;
    logic        head_ready;

    assign head_ready = head_valid & head_done;

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        req_d   = req_q;
        flush_d = flush_q;
        rv_d    = 1'b0;
        rpc_d   = rpc_q;
        commit  = 1'b0;
        rf_we   = 1'b0;
        rf_rd   = 5'd0;
        rf_data = 32'd0;
        rf_tag  = '0;

        case (state_q)
            S_RUN: begin
                if (head_ready) begin
                    if (head_is_store) begin
                        state_d = S_STORE;
                        req_d   = 1'b1;
                    end else begin
                        // Mispredicted jumps still write their link register.
                        commit  = 1'b1;
                        rf_we   = (head_rd != 5'd0);
                        rf_rd   = head_rd;
                        rf_data = head_value;
                        rf_tag  = head_idx;
                        if (head_mispred) begin
                            state_d = S_FLUSH;
                            fcnt_d  = FLUSH_LOAD;
                            flush_d = 1'b1;
                            rv_d    = 1'b1;
                            rpc_d   = head_target;
                        end
                    end
                end
            end
            S_STORE: begin
                if (st_commit_ack) begin
                    commit  = 1'b1;
                    rf_tag  = head_idx;
                    req_d   = 1'b0;
                    state_d = S_RUN;
                end
            end
            S_FLUSH: begin
                // Counter holds the flush cycles still to run, this one included.
                fcnt_d = fcnt_q - 4'd1;
                if (fcnt_q <= 4'd1) begin
                    fcnt_d  = 4'd0;
                    flush_d = 1'b0;
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_RUN;
                fcnt_d  = 4'd0;
                req_d   = 1'b0;
                flush_d = 1'b0;
            end
        endcase
    end

    assign retired_cnt_d = retired_cnt_q + {31'd0, commit};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_RUN;
            fcnt_q        <= 4'd0;
            req_q         <= 1'b0;
            flush_q       <= 1'b0;
            rv_q          <= 1'b0;
            rpc_q         <= 32'd0;
            retired_cnt_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            fcnt_q        <= fcnt_d;
            req_q         <= req_d;
            flush_q       <= flush_d;
            rv_q          <= rv_d;
            rpc_q         <= rpc_d;
            retired_cnt_q <= retired_cnt_d;
        end
    end

    assign st_commit_req  = req_q;
    assign flush          = flush_q;
    assign redirect_valid = rv_q;
    assign redirect_pc    = rpc_q;
    assign retired_cnt    = retired_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_rob_commit_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_rob_commit_unit
// Brief    : Directed scoreboard bench for rob_commit_unit.
// Revision : 1.0  initial release
// ============================================================================
module tb_rob_commit_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        head_valid, head_done, head_is_store, head_mispred, st_commit_ack;
    logic [4:0]  head_idx, head_rd;
    logic [31:0] head_value, head_target;
    logic        commit, rf_we, st_commit_req, flush, redirect_valid;
    logic [4:0]  rf_rd, rf_tag;
    logic [31:0] rf_data, redirect_pc, retired_cnt;

    int checks = 0;
    int fails  = 0;
    int commit_total = 0;

    typedef struct packed {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [4:0]  tag;
        logic        full;
    } exp_t;
    exp_t exp_q[$];

    rob_commit_unit #(.ROB_IDX(5), .FLUSH_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .head_valid(head_valid), .head_done(head_done), .head_idx(head_idx),
        .head_rd(head_rd), .head_value(head_value), .head_is_store(head_is_store),
        .head_mispred(head_mispred), .head_target(head_target),
        .st_commit_ack(st_commit_ack),
        .commit(commit), .rf_we(rf_we), .rf_rd(rf_rd), .rf_data(rf_data),
        .rf_tag(rf_tag), .st_commit_req(st_commit_req), .flush(flush),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .retired_cnt(retired_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic hd(input logic v, input logic d, input logic [4:0] idx, input logic [4:0] rd,
                      input logic [31:0] val, input logic st, input logic mp, input logic [31:0] tgt);
        head_valid = v; head_done = d; head_idx = idx; head_rd = rd;
        head_value = val; head_is_store = st; head_mispred = mp; head_target = tgt;
    endtask

    task automatic idle();
        hd(1'b0, 1'b0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic push(input logic we, input logic [4:0] rd, input logic [31:0] data,
                        input logic [4:0] tag, input logic full);
        exp_t e;
        e.we = we; e.rd = rd; e.data = data; e.tag = tag; e.full = full;
        exp_q.push_back(e);
    endtask

    // Monitor: every commit pops the next expected retirement.
    always @(negedge clk) begin
        if (!rst && commit) begin
            commit_total++;
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_commit actual=tag %h required=no commit", rf_tag);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("commit_rf_we", {31'd0, rf_we}, {31'd0, e.we});
                chk("commit_rf_tag", {27'd0, rf_tag}, {27'd0, e.tag});
                if (e.full) begin
                    chk("commit_rf_rd", {27'd0, rf_rd}, {27'd0, e.rd});
                    chk("commit_rf_data", rf_data, e.data);
                end
            end
        end
    end

    initial begin
        int base;
        int req_cnt;
        logic [3:0] fl, rv, cm;
        logic [31:0] pc1;

        rst = 1'b1;
        st_commit_ack = 1'b0;
        idle();
        repeat (3) nxt();
        chk("rst_req", {31'd0, st_commit_req}, 32'd0);
        chk("rst_flush", {31'd0, flush}, 32'd0);
        chk("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        chk("rst_redirect_pc", redirect_pc, 32'd0);
        chk("rst_retired_cnt", retired_cnt, 32'd0);
        chk("rst_commit", {31'd0, commit}, 32'd0);
        rst = 1'b0;

        // Back-to-back retirements, rd=0 suppresses the write.
        base = commit_total;
        push(1'b1, 5'd5, 32'h11, 5'd0, 1'b1);
        hd(1'b1, 1'b1, 5'd0, 5'd5, 32'h11, 1'b0, 1'b0, 32'd0);
        nxt();
        push(1'b1, 5'd6, 32'h22, 5'd1, 1'b1);
        hd(1'b1, 1'b1, 5'd1, 5'd6, 32'h22, 1'b0, 1'b0, 32'd0);
        nxt();
        push(1'b0, 5'd0, 32'h33, 5'd2, 1'b1);
        hd(1'b1, 1'b1, 5'd2, 5'd0, 32'h33, 1'b0, 1'b0, 32'd0);
        nxt();
        idle();
        chk("b2b_commits", commit_total - base, 32'd3);
        chk("b2b_retired_cnt", retired_cnt, 32'd3);

        // Store held off for 4 cycles, then acknowledged.
        base = commit_total;
        req_cnt = 0;
        hd(1'b1, 1'b1, 5'd3, 5'd7, 32'h77, 1'b1, 1'b0, 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (st_commit_req) req_cnt++;
            nxt();
        end
        chk("store_no_early_commit", commit_total - base, 32'd0);
        push(1'b0, 5'd0, 32'd0, 5'd3, 1'b0);
        st_commit_ack = 1'b1;
        @(negedge clk);
        if (st_commit_req) req_cnt++;
        chk("store_ack_commit", {31'd0, commit}, 32'd1);
        nxt();
        st_commit_ack = 1'b0;
        idle();
        chk("store_req_cycles", req_cnt, 32'd5);
        chk("store_req_cleared", {31'd0, st_commit_req}, 32'd0);
        chk("store_commits", commit_total - base, 32'd1);
        chk("store_retired_cnt", retired_cnt, 32'd4);

        // Mispredict: flush for 2 cycles, ready head waits it out.
        base = commit_total;
        push(1'b1, 5'd1, 32'h100, 5'd4, 1'b1);
        push(1'b1, 5'd2, 32'h55, 5'd5, 1'b1);
        hd(1'b1, 1'b1, 5'd4, 5'd1, 32'h100, 1'b0, 1'b1, 32'h8000_0040);
        @(negedge clk);
        chk("mp_commit_and_we", {31'd0, commit & rf_we}, 32'd1);
        pc1 = 32'd0;
        for (int k = 1; k <= 3; k++) begin
            nxt();
            if (k == 1) hd(1'b1, 1'b1, 5'd5, 5'd2, 32'h55, 1'b0, 1'b0, 32'd0);
            @(negedge clk);
            fl[k] = flush; rv[k] = redirect_valid; cm[k] = commit;
            if (k == 1) pc1 = redirect_pc;
        end
        nxt();
        idle();
        chk("mp_flush_pattern", {29'd0, fl[3:1]}, 32'b011);
        chk("mp_redirect_pattern", {29'd0, rv[3:1]}, 32'b001);
        chk("mp_redirect_pc", pc1, 32'h8000_0040);
        chk("mp_commit_pattern", {29'd0, cm[3:1]}, 32'b100);
        chk("mp_commits", commit_total - base, 32'd2);
        chk("mp_retired_cnt", retired_cnt, 32'd6);

        // Not-ready heads: done low, then done without valid.
        base = commit_total;
        hd(1'b1, 1'b0, 5'd7, 5'd3, 32'h99, 1'b0, 1'b0, 32'd0);
        repeat (10) nxt();
        hd(1'b0, 1'b1, 5'd7, 5'd3, 32'h99, 1'b0, 1'b0, 32'd0);
        st_commit_ack = 1'b1;
        repeat (3) nxt();
        st_commit_ack = 1'b0;
        idle();
        chk("notready_commits", commit_total - base, 32'd0);
        chk("notready_retired_cnt", retired_cnt, 32'd6);

        // Reset in the middle of a pending store.
        hd(1'b1, 1'b1, 5'd6, 5'd3, 32'h66, 1'b1, 1'b0, 32'd0);
        nxt();
        nxt();
        chk("midstore_req_before_rst", {31'd0, st_commit_req}, 32'd1);
        base = commit_total;
        rst = 1'b1;
        #1;
        chk("midrst_req", {31'd0, st_commit_req}, 32'd0);
        chk("midrst_flush", {31'd0, flush}, 32'd0);
        chk("midrst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        chk("midrst_redirect_pc", redirect_pc, 32'd0);
        chk("midrst_retired_cnt", retired_cnt, 32'd0);
        nxt();
        rst = 1'b0;
        @(negedge clk);
        chk("postrst_req_first", {31'd0, st_commit_req}, 32'd0);
        nxt();
        @(negedge clk);
        chk("postrst_req_restart", {31'd0, st_commit_req}, 32'd1);
        chk("postrst_no_commit", {31'd0, commit}, 32'd0);
        nxt();
        push(1'b0, 5'd0, 32'd0, 5'd6, 1'b0);
        st_commit_ack = 1'b1;
        nxt();
        st_commit_ack = 1'b0;
        idle();
        chk("postrst_commits", commit_total - base, 32'd1);
        chk("postrst_retired_cnt", retired_cnt, 32'd1);

        // Counter wrap.
        force dut.retired_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.retired_cnt_q;
        #1;
        chk("wrap_preload", retired_cnt, 32'hFFFF_FFFF);
        push(1'b1, 5'd9, 32'hABC, 5'd8, 1'b1);
        hd(1'b1, 1'b1, 5'd8, 5'd9, 32'hABC, 1'b0, 1'b0, 32'd0);
        nxt();
        idle();
        chk("wrap_to_zero", retired_cnt, 32'd0);

        repeat (2) nxt();
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
